// File: rtl/data_path_pkg.sv
// rtl/data_path_pkg.sv - shared widths and encodings for the data_path load sequencer
package data_path_pkg;

   localparam int DATA_W = 48;
   localparam int WORD_W = 16;
   localparam int CODE_W = 12;
   localparam int IDX_W  = 32;

   typedef enum logic [2:0] {
      TGT_CODE    = 3'd0,
      TGT_WEIGHT  = 3'd1,
      TGT_INPUT   = 3'd2,
      TGT_LABEL   = 3'd3,
      TGT_LOC_RST = 3'd4,
      TGT_START   = 3'd5,
      TGT_CLR_ERR = 3'd6,
      TGT_RSVD    = 3'd7
   } cmd_target_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ARM  = 2'd1,
      ST_RUN  = 2'd2,
      ST_DONE = 2'd3
   } seq_state_e;

endpackage

// File: rtl/run_watchdog.sv
// rtl/run_watchdog.sv - saturating RUN cycle counter with timeout compare
module run_watchdog
   import data_path_pkg::*;
#(
   parameter int unsigned TIMEOUT = 4096
) (
   input  logic             clk_clk,
   input  logic             reset_reset_n,
   input  logic             clear_i,
   input  logic             enable_i,
   output logic [IDX_W-1:0] count_o,
   output logic             expired_o
);

   // Count reaches TIMEOUT-1 during the last permitted RUN cycle.
   localparam logic [IDX_W-1:0] LAST_CNT = IDX_W'(TIMEOUT - 1);

   logic [IDX_W-1:0] count_q;

   // Clear wins over counting; the count sticks at all-ones instead of wrapping.
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         count_q <= '0;
      end else if (clear_i) begin
         count_q <= '0;
      end else if (enable_i && (count_q != '1)) begin
         count_q <= count_q + 1'b1;
      end
   end

   assign count_o   = count_q;
   assign expired_o = (TIMEOUT != 0) && (count_q == LAST_CNT);

endmodule

// File: rtl/data_path_load_sequencer.sv
// rtl/data_path_load_sequencer.sv - command-driven storage loader and run sequencer
module data_path_load_sequencer
   import data_path_pkg::*;
#(
   parameter int unsigned MAX_LAYERS = 4,
   parameter int unsigned MAX_ROWS   = 64,
   parameter int unsigned CODE_DEPTH = 256,
   parameter int unsigned TIMEOUT    = 4096
) (
   input  logic              clk_clk,
   input  logic              reset_reset_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [2:0]        cmd_target,
   input  logic [IDX_W-1:0]  cmd_layer_index,
   input  logic [IDX_W-1:0]  cmd_row_index,
   input  logic [DATA_W-1:0] cmd_data,
   input  logic              controller_done,
   output logic [IDX_W-1:0]  wr_layer_index,
   output logic [IDX_W-1:0]  wr_row_index,
   output logic [DATA_W-1:0] wr_data,
   output logic              code_is_write,
   output logic              weight_is_write,
   output logic              input_is_write,
   output logic              label_is_write,
   output logic              locator_reset,
   output logic              code_storage_enable,
   output logic              controller_enable,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [IDX_W-1:0]  run_cycles
);

   seq_state_e        state_q, state_d;
   cmd_target_e       tgt;
   logic              accept, matrix_tgt, mat_ok, line_ok, wr_ok, start_go;
   logic              wd_expired, error_d;
   logic              ready_q, busy_q, done_q, error_q, cse_q, ce_q;
   logic              code_wr_q, weight_wr_q, input_wr_q, label_wr_q, loc_rst_q;
   logic [IDX_W-1:0]  layer_q, row_q;
   logic [DATA_W-1:0] data_q;

   assign tgt        = cmd_target_e'(cmd_target);
   assign accept     = cmd_valid && ready_q;
   assign matrix_tgt = (tgt == TGT_WEIGHT) || (tgt == TGT_INPUT) || (tgt == TGT_LABEL);
   assign mat_ok     = (cmd_layer_index < IDX_W'(MAX_LAYERS)) && (cmd_row_index < IDX_W'(MAX_ROWS));
   assign line_ok    = cmd_row_index < IDX_W'(CODE_DEPTH);
   assign wr_ok      = accept && (((tgt == TGT_CODE) && line_ok) || (matrix_tgt && mat_ok));
   assign start_go   = accept && (tgt == TGT_START) && !error_q;

   run_watchdog #(.TIMEOUT(TIMEOUT)) u_run_watchdog (
      .clk_clk       (clk_clk),
      .reset_reset_n (reset_reset_n),
      .clear_i       (start_go),
      .enable_i      (state_q == ST_RUN),
      .count_o       (run_cycles),
      .expired_o     (wd_expired)
   );

   // Next state: a START with a clean error flag arms; done beats timeout in RUN.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (start_go) state_d = ST_ARM;
         ST_ARM:  state_d = ST_RUN;
         ST_RUN:  if (controller_done || wd_expired) state_d = ST_DONE;
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Sticky fault: bad indices, reserved target or a timeout not rescued by done.
   always_comb begin
      error_d = error_q;
      if (accept) begin
         case (tgt)
            TGT_CODE:                          if (!line_ok) error_d = 1'b1;
            TGT_WEIGHT, TGT_INPUT, TGT_LABEL:  if (!mat_ok)  error_d = 1'b1;
            TGT_CLR_ERR:                       error_d = 1'b0;
            TGT_RSVD:                          error_d = 1'b1;
            default:                           error_d = error_q;
         endcase
      end
      if ((state_q == ST_RUN) && wd_expired && !controller_done) error_d = 1'b1;
   end

   // State and status flags, all registered from the next state so nothing is combinational.
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         state_q <= ST_IDLE;
         ready_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         error_q <= 1'b0;
         cse_q   <= 1'b0;
         ce_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         ready_q <= (state_d == ST_IDLE);
         busy_q  <= (state_d == ST_ARM) || (state_d == ST_RUN);
         done_q  <= (state_d == ST_DONE);
         error_q <= error_d;
         cse_q   <= (state_d == ST_ARM) || (state_d == ST_RUN);
         ce_q    <= (state_d == ST_RUN);
      end
   end

   // One-cycle write strobes and the shared write buses, which hold until the next good write.
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         code_wr_q   <= 1'b0;
         weight_wr_q <= 1'b0;
         input_wr_q  <= 1'b0;
         label_wr_q  <= 1'b0;
         loc_rst_q   <= 1'b0;
         layer_q     <= '0;
         row_q       <= '0;
         data_q      <= '0;
      end else begin
         code_wr_q   <= wr_ok && (tgt == TGT_CODE);
         weight_wr_q <= wr_ok && (tgt == TGT_WEIGHT);
         input_wr_q  <= wr_ok && (tgt == TGT_INPUT);
         label_wr_q  <= wr_ok && (tgt == TGT_LABEL);
         loc_rst_q   <= accept && (tgt == TGT_LOC_RST);
         if (wr_ok) begin
            layer_q <= cmd_layer_index;
            row_q   <= cmd_row_index;
            data_q  <= cmd_data;
         end
      end
   end

   assign cmd_ready           = ready_q;
   assign busy                = busy_q;
   assign done                = done_q;
   assign error               = error_q;
   assign code_storage_enable = cse_q;
   assign controller_enable   = ce_q;
   assign code_is_write       = code_wr_q;
   assign weight_is_write     = weight_wr_q;
   assign input_is_write      = input_wr_q;
   assign label_is_write      = label_wr_q;
   assign locator_reset       = loc_rst_q;
   assign wr_layer_index      = layer_q;
   assign wr_row_index        = row_q;
   assign wr_data             = data_q;

endmodule

// File: tb/tb_data_path_load_sequencer.sv
// tb/tb_data_path_load_sequencer.sv - directed self-checking bench for the load sequencer
module tb_data_path_load_sequencer;
   import data_path_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cmd_valid, ctrl_done;
   logic [2:0]  cmd_target;
   logic [31:0] cmd_layer, cmd_row;
   logic [47:0] cmd_data;

   // default-parameter instance
   logic        a_ready, a_cw, a_ww, a_iw, a_lw, a_lr, a_cse, a_ce, a_busy, a_done, a_err;
   logic [31:0] a_layer, a_row, a_rc;
   logic [47:0] a_data;
   // TIMEOUT=8 instance, driven by the same commands
   logic        b_ready, b_cw, b_ww, b_iw, b_lw, b_lr, b_cse, b_ce, b_busy, b_done, b_err;
   logic [31:0] b_layer, b_row, b_rc;
   logic [47:0] b_data;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   data_path_load_sequencer dut (
      .clk_clk(clk), .reset_reset_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(a_ready),
      .cmd_target(cmd_target), .cmd_layer_index(cmd_layer), .cmd_row_index(cmd_row),
      .cmd_data(cmd_data), .controller_done(ctrl_done), .wr_layer_index(a_layer),
      .wr_row_index(a_row), .wr_data(a_data), .code_is_write(a_cw), .weight_is_write(a_ww),
      .input_is_write(a_iw), .label_is_write(a_lw), .locator_reset(a_lr),
      .code_storage_enable(a_cse), .controller_enable(a_ce), .busy(a_busy), .done(a_done),
      .error(a_err), .run_cycles(a_rc)
   );

   data_path_load_sequencer #(.TIMEOUT(8)) dut_to (
      .clk_clk(clk), .reset_reset_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(b_ready),
      .cmd_target(cmd_target), .cmd_layer_index(cmd_layer), .cmd_row_index(cmd_row),
      .cmd_data(cmd_data), .controller_done(ctrl_done), .wr_layer_index(b_layer),
      .wr_row_index(b_row), .wr_data(b_data), .code_is_write(b_cw), .weight_is_write(b_ww),
      .input_is_write(b_iw), .label_is_write(b_lw), .locator_reset(b_lr),
      .code_storage_enable(b_cse), .controller_enable(b_ce), .busy(b_busy), .done(b_done),
      .error(b_err), .run_cycles(b_rc)
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Presents one command on a falling edge; returns at the falling edge of cycle N+1.
   task automatic send(input logic [2:0] tgt, input logic [31:0] lay, input logic [31:0] row,
                       input logic [47:0] dat);
      @(negedge clk);
      check_eq("cmd_ready_before_send", 64'(a_ready), 64'd1);
      cmd_valid  = 1'b1;
      cmd_target = tgt;
      cmd_layer  = lay;
      cmd_row    = row;
      cmd_data   = dat;
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL sim_timeout: simulation did not reach the end");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0; cmd_valid = 1'b0; ctrl_done = 1'b0;
      cmd_target = 3'd0; cmd_layer = '0; cmd_row = '0; cmd_data = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_eq("rst_ready", 64'(a_ready), 64'd0);
      check_eq("rst_strobes", 64'({a_cw, a_ww, a_iw, a_lw, a_lr}), 64'd0);
      check_eq("rst_status", 64'({a_cse, a_ce, a_busy, a_done, a_err}), 64'd0);
      check_eq("rst_run_cycles", 64'(a_rc), 64'd0);
      check_eq("rst_wr_data", 64'(a_data), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check_eq("ready_after_rst", 64'(a_ready), 64'd1);

      // weight write
      send(TGT_WEIGHT, 32'd1, 32'd5, 48'h0001_0002_0003);
      check_eq("weight_strobe", 64'(a_ww), 64'd1);
      check_eq("weight_others", 64'({a_cw, a_iw, a_lw, a_lr}), 64'd0);
      check_eq("weight_data", 64'(a_data), 64'h0001_0002_0003);
      check_eq("weight_layer", 64'(a_layer), 64'd1);
      check_eq("weight_row", 64'(a_row), 64'd5);
      @(negedge clk);
      check_eq("weight_strobe_1cyc", 64'(a_ww), 64'd0);
      check_eq("weight_data_hold", 64'(a_data), 64'h0001_0002_0003);

      // bad code line, START blocked by error, clear and start
      send(TGT_CODE, 32'd0, 32'd300, 48'h0000_0000_0123);
      check_eq("code300_strobe", 64'(a_cw), 64'd0);
      check_eq("code300_error", 64'(a_err), 64'd1);
      check_eq("code300_data_hold", 64'(a_data), 64'h0001_0002_0003);
      send(TGT_START, 32'd0, 32'd0, 48'd0);
      check_eq("start_blocked_busy", 64'(a_busy), 64'd0);
      check_eq("start_blocked_ready", 64'(a_ready), 64'd1);
      check_eq("start_blocked_cse", 64'(a_cse), 64'd0);
      send(TGT_CLR_ERR, 32'd0, 32'd0, 48'd0);
      check_eq("clr_err", 64'(a_err), 64'd0);
      check_eq("clr_err_b", 64'(b_err), 64'd0);

      // run: done on 10th RUN cycle for dut; dut_to times out after 8
      send(TGT_START, 32'd0, 32'd0, 48'd0);
      check_eq("arm_enables", 64'({a_cse, a_ce}), 64'b10);
      check_eq("arm_busy_ready", 64'({a_busy, a_ready}), 64'b10);
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (k == 1) check_eq("run_enables", 64'({a_cse, a_ce}), 64'b11);
         if (k == 8) check_eq("to_last_run", 64'({b_ce, b_err}), 64'b10);
         if (k == 9) begin
            check_eq("to_done_pulse", 64'(b_done), 64'd1);
            check_eq("to_error", 64'(b_err), 64'd1);
            check_eq("to_enables", 64'({b_cse, b_ce}), 64'd0);
            check_eq("to_run_cycles", 64'(b_rc), 64'd8);
         end
         if (k == 10) ctrl_done = 1'b1;
      end
      @(negedge clk);
      ctrl_done = 1'b0;
      check_eq("done_pulse", 64'(a_done), 64'd1);
      check_eq("done_enables", 64'({a_cse, a_ce, a_busy}), 64'd0);
      check_eq("done_run_cycles", 64'(a_rc), 64'd10);
      check_eq("done_no_error", 64'(a_err), 64'd0);
      @(negedge clk);
      check_eq("done_1cyc", 64'(a_done), 64'd0);
      check_eq("idle_ready", 64'(a_ready), 64'd1);

      // done and timeout together on dut_to: done wins
      send(TGT_CLR_ERR, 32'd0, 32'd0, 48'd0);
      send(TGT_START, 32'd0, 32'd0, 48'd0);
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         if (k == 8) ctrl_done = 1'b1;
      end
      @(negedge clk);
      ctrl_done = 1'b0;
      check_eq("tie_done_pulse", 64'(b_done), 64'd1);
      check_eq("tie_no_error", 64'(b_err), 64'd0);
      check_eq("tie_run_cycles", 64'(b_rc), 64'd8);
      check_eq("tie_main_run_cycles", 64'(a_rc), 64'd8);
      @(negedge clk);

      // controller_done outside RUN
      ctrl_done = 1'b1;
      repeat (2) @(negedge clk);
      check_eq("idle_done_ignored", 64'({a_done, a_busy, a_cse}), 64'd0);
      ctrl_done = 1'b0;

      // index boundaries and other targets
      send(TGT_WEIGHT, 32'd4, 32'd0, 48'h1111_2222_3333);
      check_eq("layer4_strobe", 64'(a_ww), 64'd0);
      check_eq("layer4_error", 64'(a_err), 64'd1);
      send(TGT_CLR_ERR, 32'd0, 32'd0, 48'd0);
      send(TGT_INPUT, 32'd3, 32'd63, 48'hAAAA_BBBB_CCCC);
      check_eq("input_edge_strobe", 64'(a_iw), 64'd1);
      check_eq("input_edge_row", 64'(a_row), 64'd63);
      check_eq("input_edge_error", 64'(a_err), 64'd0);
      send(TGT_LABEL, 32'd0, 32'd64, 48'h0);
      check_eq("row64_strobe", 64'(a_lw), 64'd0);
      check_eq("row64_error", 64'(a_err), 64'd1);
      send(TGT_CLR_ERR, 32'd0, 32'd0, 48'd0);
      send(TGT_CODE, 32'd0, 32'd255, 48'h0000_0000_0ABC);
      check_eq("code255_strobe", 64'(a_cw), 64'd1);
      check_eq("code255_data", 64'(a_data[11:0]), 64'h0ABC);
      check_eq("code255_line", 64'(a_row), 64'd255);
      send(TGT_LOC_RST, 32'd0, 32'd0, 48'd0);
      check_eq("loc_rst_pulse", 64'(a_lr), 64'd1);
      @(negedge clk);
      check_eq("loc_rst_1cyc", 64'(a_lr), 64'd0);
      send(TGT_RSVD, 32'd0, 32'd0, 48'd0);
      check_eq("rsvd_error", 64'(a_err), 64'd1);
      check_eq("rsvd_ready", 64'(a_ready), 64'd1);
      send(TGT_CLR_ERR, 32'd0, 32'd0, 48'd0);

      // asynchronous reset in the middle of RUN
      send(TGT_START, 32'd0, 32'd0, 48'd0);
      repeat (3) @(negedge clk);
      check_eq("pre_rst_run", 64'({a_cse, a_ce}), 64'b11);
      #2 rst_n = 1'b0;
      #1;
      check_eq("async_rst_enables", 64'({a_cse, a_ce, b_cse, b_ce}), 64'd0);
      check_eq("async_rst_busy", 64'(a_busy), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_eq("post_rst_ready", 64'(a_ready), 64'd1);
      check_eq("post_rst_run_cycles", 64'(a_rc), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
